// File: rtl/br_resolve.sv
// Branch resolution: checks resolved branches against fetch-time predictions and
// sequences mispredict recovery. Optional BR_RESOLVE_STATS_EN adds resolve/mispredict counters.
module br_resolve #(
  parameter int unsigned ROB_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_en_i,
  input  logic [ROB_IDX_W-1:0] disp_rob_idx_i,
  input  logic [63:0]          disp_npc_i,
  input  logic                 disp_pred_taken_i,
  input  logic [63:0]          disp_pred_target_i,
  input  logic [ROB_IDX_W-1:0] rob_head_idx_i,
  input  logic                 br_done_i,
  input  logic [ROB_IDX_W-1:0] br_rob_idx_i,
  input  logic                 br_result_i,
  input  logic [63:0]          br_target_i,
  input  logic                 recover_ack_i,
  output logic                 mispredict_o,
  output logic [63:0]          redirect_pc_o,
  output logic [ROB_IDX_W-1:0] mispredict_rob_idx_o,
  output logic                 busy_o,
  output logic                 bp_upd_valid_o,
  output logic [63:0]          bp_upd_pc_o,
  output logic                 bp_upd_taken_o,
  output logic [63:0]          bp_upd_target_o
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [31:0]          stat_resolved_o,
  output logic [31:0]          stat_mispred_o
`endif
);

  localparam int unsigned Entries = 2 ** ROB_IDX_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFlush = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [Entries-1:0]   valid_q, valid_d;
  logic [63:0]          npc_tbl [Entries];
  logic [63:0]          tgt_tbl [Entries];
  logic [Entries-1:0]   ptk_tbl;

  logic [63:0]          redirect_pc_q;
  logic [ROB_IDX_W-1:0] mis_idx_q;
  logic                 bp_upd_valid_q;
  logic [63:0]          bp_upd_pc_q;
  logic                 bp_upd_taken_q;
  logic [63:0]          bp_upd_target_q;

  logic                 disp_we;
  logic                 res_vld;
  logic                 res_mis;
  logic                 take_flush;
  logic [63:0]          res_npc;
  logic [63:0]          res_pc;
  logic [ROB_IDX_W-1:0] br_age;
  logic [ROB_IDX_W-1:0] mis_age;

  assign disp_we = disp_en_i && (state_q == StIdle);
  assign res_vld = br_done_i && valid_q[br_rob_idx_i];
  assign res_npc = npc_tbl[br_rob_idx_i];
  assign res_mis = res_vld && ((br_result_i != ptk_tbl[br_rob_idx_i]) ||
                               (br_result_i && (br_target_i != tgt_tbl[br_rob_idx_i])));
  assign res_pc  = br_result_i ? br_target_i : res_npc;

  // Ages are relative to the current ROB head; smaller means older.
  assign br_age  = br_rob_idx_i - rob_head_idx_i;
  assign mis_age = mis_idx_q - rob_head_idx_i;

  // During recovery only a strictly older mispredict replaces the latched one.
  assign take_flush = res_mis && ((state_q == StIdle) || (br_age < mis_age));

  always_comb begin
    logic [ROB_IDX_W-1:0] entry_age;
    entry_age = '0;
    valid_d   = valid_q;
    if (disp_we) valid_d[disp_rob_idx_i] = 1'b1;
    if (res_vld) valid_d[br_rob_idx_i] = 1'b0;
    if (take_flush) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        entry_age = ROB_IDX_W'(i) - rob_head_idx_i;
        if (entry_age > br_age) valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StIdle;
      StFlush: state_d = StWait;
      StWait:  if (recover_ack_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (take_flush) state_d = StFlush;
  end

  // Table payload needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (disp_we) begin
      npc_tbl[disp_rob_idx_i] <= disp_npc_i;
      tgt_tbl[disp_rob_idx_i] <= disp_pred_target_i;
      ptk_tbl[disp_rob_idx_i] <= disp_pred_taken_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      valid_q         <= '0;
      redirect_pc_q   <= '0;
      mis_idx_q       <= '0;
      bp_upd_valid_q  <= 1'b0;
      bp_upd_pc_q     <= '0;
      bp_upd_taken_q  <= 1'b0;
      bp_upd_target_q <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      bp_upd_valid_q <= res_vld;
      if (res_vld) begin
        bp_upd_pc_q     <= res_npc - 64'd4;
        bp_upd_taken_q  <= br_result_i;
        bp_upd_target_q <= br_target_i;
      end
      if (take_flush) begin
        redirect_pc_q <= res_pc;
        mis_idx_q     <= br_rob_idx_i;
      end
    end
  end

  assign mispredict_o         = (state_q == StFlush);
  assign busy_o               = (state_q != StIdle);
  assign redirect_pc_o        = redirect_pc_q;
  assign mispredict_rob_idx_o = mis_idx_q;
  assign bp_upd_valid_o       = bp_upd_valid_q;
  assign bp_upd_pc_o          = bp_upd_pc_q;
  assign bp_upd_taken_o       = bp_upd_taken_q;
  assign bp_upd_target_o      = bp_upd_target_q;

`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] stat_resolved_q;
  logic [31:0] stat_mispred_q;

  // Counters move on the same edge that raises bp_upd_valid_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (res_vld && (stat_resolved_q != 32'hFFFF_FFFF)) stat_resolved_q <= stat_resolved_q + 32'd1;
      if (res_mis && (stat_mispred_q != 32'hFFFF_FFFF)) stat_mispred_q <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_resolved_o = stat_resolved_q;
  assign stat_mispred_o  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve: vector table for single-cycle behaviour plus
// hand sequences for nested recovery, ROB wrap-around and reset during recovery.
module tb_br_resolve;

  logic        clk;
  logic        rst;
  logic        disp_en_i;
  logic [4:0]  disp_rob_idx_i;
  logic [63:0] disp_npc_i;
  logic        disp_pred_taken_i;
  logic [63:0] disp_pred_target_i;
  logic [4:0]  rob_head_idx_i;
  logic        br_done_i;
  logic [4:0]  br_rob_idx_i;
  logic        br_result_i;
  logic [63:0] br_target_i;
  logic        recover_ack_i;
  logic        mispredict_o;
  logic [63:0] redirect_pc_o;
  logic [4:0]  mispredict_rob_idx_o;
  logic        busy_o;
  logic        bp_upd_valid_o;
  logic [63:0] bp_upd_pc_o;
  logic        bp_upd_taken_o;
  logic [63:0] bp_upd_target_o;
`ifdef BR_RESOLVE_STATS_EN
  logic [31:0] stat_resolved_o;
  logic [31:0] stat_mispred_o;
`endif

  br_resolve #(.ROB_IDX_W(5)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .disp_en_i            (disp_en_i),
    .disp_rob_idx_i       (disp_rob_idx_i),
    .disp_npc_i           (disp_npc_i),
    .disp_pred_taken_i    (disp_pred_taken_i),
    .disp_pred_target_i   (disp_pred_target_i),
    .rob_head_idx_i       (rob_head_idx_i),
    .br_done_i            (br_done_i),
    .br_rob_idx_i         (br_rob_idx_i),
    .br_result_i          (br_result_i),
    .br_target_i          (br_target_i),
    .recover_ack_i        (recover_ack_i),
    .mispredict_o         (mispredict_o),
    .redirect_pc_o        (redirect_pc_o),
    .mispredict_rob_idx_o (mispredict_rob_idx_o),
    .busy_o               (busy_o),
    .bp_upd_valid_o       (bp_upd_valid_o),
    .bp_upd_pc_o          (bp_upd_pc_o),
    .bp_upd_taken_o       (bp_upd_taken_o),
    .bp_upd_target_o      (bp_upd_target_o)
`ifdef BR_RESOLVE_STATS_EN
    ,
    .stat_resolved_o      (stat_resolved_o),
    .stat_mispred_o       (stat_mispred_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  typedef struct packed {
    logic        de;
    logic [4:0]  di;
    logic [63:0] dn;
    logic        dt;
    logic [63:0] dg;
    logic        bd;
    logic [4:0]  bi;
    logic        br;
    logic [63:0] bt;
    logic        ack;
    logic        ev;
    logic [63:0] epc;
    logic        et;
    logic        em;
    logic        eb;
    logic [63:0] erp;
    logic [4:0]  ei;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    disp_en_i          = 1'b0;
    disp_rob_idx_i     = '0;
    disp_npc_i         = '0;
    disp_pred_taken_i  = 1'b0;
    disp_pred_target_i = '0;
    br_done_i          = 1'b0;
    br_rob_idx_i       = '0;
    br_result_i        = 1'b0;
    br_target_i        = '0;
    recover_ack_i      = 1'b0;
  endtask

  task automatic do_disp(input logic [4:0] idx, input logic [63:0] npc, input logic pt,
                         input logic [63:0] tg);
    disp_en_i          = 1'b1;
    disp_rob_idx_i     = idx;
    disp_npc_i         = npc;
    disp_pred_taken_i  = pt;
    disp_pred_target_i = tg;
    tick();
    idle_in();
  endtask

  task automatic do_res(input logic [4:0] idx, input logic r, input logic [63:0] t);
    br_done_i    = 1'b1;
    br_rob_idx_i = idx;
    br_result_i  = r;
    br_target_i  = t;
    tick();
    idle_in();
  endtask

  task automatic do_ack();
    recover_ack_i = 1'b1;
    tick();
    idle_in();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    idle_in();
    rob_head_idx_i = '0;

    //        de  di   dn      dt  dg      bd  bi  br  bt      ack ev  epc     et  em  eb  erp     ei
    vecs[0]  = '{0, 0,  0,      0, 0,      0, 0,  0, 0,      0,  0, 0,      0, 0, 0, 0,      0};
    vecs[1]  = '{1, 3,  'h104,  1, 'h200,  0, 0,  0, 0,      0,  0, 0,      0, 0, 0, 0,      0};
    vecs[2]  = '{0, 0,  0,      0, 0,      1, 3,  1, 'h200,  0,  1, 'h100,  1, 0, 0, 0,      0};
    vecs[3]  = '{0, 0,  0,      0, 0,      1, 3,  1, 'h200,  0,  0, 0,      0, 0, 0, 0,      0};
    vecs[4]  = '{1, 4,  'h204,  0, 0,      0, 0,  0, 0,      0,  0, 0,      0, 0, 0, 0,      0};
    vecs[5]  = '{0, 0,  0,      0, 0,      1, 4,  1, 'h300,  0,  1, 'h200,  1, 1, 1, 'h300,  4};
    vecs[6]  = '{0, 0,  0,      0, 0,      0, 0,  0, 0,      0,  0, 0,      0, 0, 1, 'h300,  4};
    vecs[7]  = '{1, 5,  'h504,  0, 0,      0, 0,  0, 0,      0,  0, 0,      0, 0, 1, 'h300,  4};
    vecs[8]  = '{0, 0,  0,      0, 0,      0, 0,  0, 0,      1,  0, 0,      0, 0, 0, 'h300,  4};
    vecs[9]  = '{0, 0,  0,      0, 0,      1, 5,  1, 'h600,  0,  0, 0,      0, 0, 0, 'h300,  4};
    vecs[10] = '{0, 0,  0,      0, 0,      1, 9,  1, 'h10,   0,  0, 0,      0, 0, 0, 'h300,  4};
    vecs[11] = '{1, 7,  'h704,  1, 'h800,  0, 0,  0, 0,      0,  0, 0,      0, 0, 0, 'h300,  4};
    vecs[12] = '{1, 8,  'h804,  0, 0,      1, 7,  1, 'h800,  0,  1, 'h700,  1, 0, 0, 'h300,  4};
    vecs[13] = '{0, 0,  0,      0, 0,      1, 8,  0, 0,      0,  1, 'h800,  0, 0, 0, 'h300,  4};
    vecs[14] = '{1, 10, 'hA04,  1, 'hB00,  0, 0,  0, 0,      0,  0, 0,      0, 0, 0, 'h300,  4};
    vecs[15] = '{0, 0,  0,      0, 0,      1, 10, 0, 0,      0,  1, 'hA00,  0, 1, 1, 'hA04,  10};
    vecs[16] = '{0, 0,  0,      0, 0,      0, 0,  0, 0,      1,  0, 0,      0, 0, 1, 'hA04,  10};
    vecs[17] = '{0, 0,  0,      0, 0,      0, 0,  0, 0,      0,  0, 0,      0, 0, 1, 'hA04,  10};
    vecs[18] = '{0, 0,  0,      0, 0,      0, 0,  0, 0,      1,  0, 0,      0, 0, 0, 'hA04,  10};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst mispredict", 64'(mispredict_o), 64'd0);
    chk("rst busy", 64'(busy_o), 64'd0);
    chk("rst redirect", redirect_pc_o, 64'd0);
    chk("rst mis_idx", 64'(mispredict_rob_idx_o), 64'd0);
    chk("rst upd_valid", 64'(bp_upd_valid_o), 64'd0);
    chk("rst upd_pc", bp_upd_pc_o, 64'd0);
    chk("rst upd_taken", 64'(bp_upd_taken_o), 64'd0);
    chk("rst upd_target", bp_upd_target_o, 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 19; v++) begin
      disp_en_i          = vecs[v].de;
      disp_rob_idx_i     = vecs[v].di;
      disp_npc_i         = vecs[v].dn;
      disp_pred_taken_i  = vecs[v].dt;
      disp_pred_target_i = vecs[v].dg;
      br_done_i          = vecs[v].bd;
      br_rob_idx_i       = vecs[v].bi;
      br_result_i        = vecs[v].br;
      br_target_i        = vecs[v].bt;
      recover_ack_i      = vecs[v].ack;
      tick();
      idle_in();
      chk($sformatf("v%0d upd_valid", v), 64'(bp_upd_valid_o), 64'(vecs[v].ev));
      chk($sformatf("v%0d mispredict", v), 64'(mispredict_o), 64'(vecs[v].em));
      chk($sformatf("v%0d busy", v), 64'(busy_o), 64'(vecs[v].eb));
      chk($sformatf("v%0d redirect", v), redirect_pc_o, vecs[v].erp);
      chk($sformatf("v%0d mis_idx", v), 64'(mispredict_rob_idx_o), 64'(vecs[v].ei));
      if (vecs[v].ev) begin
        chk($sformatf("v%0d upd_pc", v), bp_upd_pc_o, vecs[v].epc);
        chk($sformatf("v%0d upd_taken", v), 64'(bp_upd_taken_o), 64'(vecs[v].et));
        if (vecs[v].br) chk($sformatf("v%0d upd_target", v), bp_upd_target_o, vecs[v].bt);
      end
    end

    // Older mispredict during WAIT re-flushes and squashes entries younger than it
    do_disp(2, 64'h40, 1'b1, 64'h1000);
    do_disp(4, 64'h50, 1'b0, 64'h0);
    do_disp(6, 64'h64, 1'b0, 64'h0);
    do_res(6, 1'b1, 64'h700);
    chk("nest first mispredict", 64'(mispredict_o), 64'd1);
    chk("nest first redirect", redirect_pc_o, 64'h700);
    chk("nest first idx", 64'(mispredict_rob_idx_o), 64'd6);
    tick();
    chk("nest wait busy", 64'(busy_o), 64'd1);
    do_res(2, 1'b0, 64'h0);
    chk("nest second upd_valid", 64'(bp_upd_valid_o), 64'd1);
    chk("nest second upd_pc", bp_upd_pc_o, 64'h3C);
    chk("nest second mispredict", 64'(mispredict_o), 64'd1);
    chk("nest second redirect", redirect_pc_o, 64'h40);
    chk("nest second idx", 64'(mispredict_rob_idx_o), 64'd2);
    tick();
    chk("nest pulse ends", 64'(mispredict_o), 64'd0);
    do_ack();
    chk("nest busy clears", 64'(busy_o), 64'd0);
    do_res(6, 1'b1, 64'h700);
    chk("nest stale 6 no upd", 64'(bp_upd_valid_o), 64'd0);
    chk("nest stale 6 no flush", 64'(mispredict_o), 64'd0);
    do_res(4, 1'b1, 64'h10);
    chk("nest squashed 4 no upd", 64'(bp_upd_valid_o), 64'd0);
    chk("nest squashed 4 not busy", 64'(busy_o), 64'd0);

    // Wrap-around age: head 30, mispredict at 1 keeps 31, clears 5 and 29
    rob_head_idx_i = 5'd30;
    do_disp(31, 64'h1F4, 1'b0, 64'h0);
    do_disp(1, 64'h14, 1'b0, 64'h0);
    do_disp(5, 64'h5C, 1'b0, 64'h0);
    do_disp(29, 64'h1D4, 1'b0, 64'h0);
    do_res(1, 1'b1, 64'h999);
    chk("wrap mispredict", 64'(mispredict_o), 64'd1);
    chk("wrap redirect", redirect_pc_o, 64'h999);
    chk("wrap idx", 64'(mispredict_rob_idx_o), 64'd1);
    tick();
    do_res(31, 1'b0, 64'h0);
    chk("wrap 31 upd_valid", 64'(bp_upd_valid_o), 64'd1);
    chk("wrap 31 upd_pc", bp_upd_pc_o, 64'h1F0);
    chk("wrap correct in wait busy", 64'(busy_o), 64'd1);
    chk("wrap correct in wait no pulse", 64'(mispredict_o), 64'd0);
    chk("wrap redirect held", redirect_pc_o, 64'h999);
    do_ack();
    do_res(5, 1'b1, 64'h10);
    chk("wrap 5 cleared", 64'(bp_upd_valid_o), 64'd0);
    do_res(29, 1'b1, 64'h10);
    chk("wrap 29 cleared", 64'(bp_upd_valid_o), 64'd0);
    chk("wrap 29 no flush", 64'(busy_o), 64'd0);
    rob_head_idx_i = 5'd0;

    // Reset during WAIT aborts recovery and clears the table
    do_disp(11, 64'hB04, 1'b0, 64'h0);
    do_disp(12, 64'hC04, 1'b0, 64'h0);
    do_res(12, 1'b1, 64'hD00);
    chk("rstw mispredict", 64'(mispredict_o), 64'd1);
    tick();
    chk("rstw busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw busy", 64'(busy_o), 64'd0);
    chk("rstw mispredict", 64'(mispredict_o), 64'd0);
    chk("rstw redirect", redirect_pc_o, 64'd0);
    chk("rstw idx", 64'(mispredict_rob_idx_o), 64'd0);
    chk("rstw upd_valid", 64'(bp_upd_valid_o), 64'd0);
    do_res(11, 1'b1, 64'h10);
    chk("rstw table cleared", 64'(bp_upd_valid_o), 64'd0);

`ifdef BR_RESOLVE_STATS_EN
    for (int k = 0; k < 3; k++) begin
      do_disp(1, 64'h104, 1'b1, 64'h200);
      do_res(1, 1'b1, 64'h200);
    end
    do_disp(2, 64'h204, 1'b0, 64'h0);
    do_res(2, 1'b1, 64'h300);
    tick();
    do_ack();
    chk("stat resolved", 64'(stat_resolved_o), 64'd4);
    chk("stat mispred", 64'(stat_mispred_o), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/br_resolve.md
Name: br_resolve

Overview:
- Consumer end of the branch-FU result interface (done, target, taken result, ROB index).
- Keeps each in-flight branch's fetch-time prediction in a table indexed by ROB index and compares it with the resolved outcome.
- On a mispredict, sequences recovery: a one-cycle flush and a redirect PC toward ROB and fetch, then waits for fetch to acknowledge.
- On every resolved branch, emits a predictor-update record.

Parameters:
- ROB_IDX_W, 5, ROB index width; the table has 2**ROB_IDX_W entries.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- disp_en_i  in  1  branch dispatched this cycle
- disp_rob_idx_i  in  ROB_IDX_W  ROB slot of the dispatched branch
- disp_npc_i  in  64  PC+4 of the dispatched branch
- disp_pred_taken_i  in  1  predicted direction
- disp_pred_target_i  in  64  predicted target
- rob_head_idx_i  in  ROB_IDX_W  current ROB head, used as the age reference
- br_done_i  in  1  branch FU result valid
- br_rob_idx_i  in  ROB_IDX_W  ROB index of the resolved branch
- br_result_i  in  1  actual taken
- br_target_i  in  64  actual taken target
- recover_ack_i  in  1  fetch has accepted the redirect
- mispredict_o  out  1  one-cycle flush pulse
- redirect_pc_o  out  64  correct next PC
- mispredict_rob_idx_o  out  ROB_IDX_W  ROB index of the mispredicting branch; ROB squashes everything younger
- busy_o  out  1  recovery in progress; dispatch must stall
- bp_upd_valid_o  out  1  predictor update strobe
- bp_upd_pc_o  out  64  branch PC (disp_npc - 4)
- bp_upd_taken_o  out  1  actual direction
- bp_upd_target_o  out  64  actual target

Behaviour:
- Reset: every output is 0, every table valid bit is cleared, FSM goes to IDLE.
- Dispatch:
  - When disp_en_i && !busy_o: write npc, pred_taken and pred_target to entry[disp_rob_idx_i] and set its valid bit.
  - Dispatch while busy_o=1 is ignored.
- Resolve: when br_done_i is high and entry[br_rob_idx_i] is valid:
  - mis = (br_result_i != pred_taken) || (br_result_i && br_target_i != pred_target).
  - Correct PC = br_result_i ? br_target_i : npc.
  - Clear the valid bit.
  - br_done_i on an invalid entry is dropped; no output and no state change.
- Outputs are registered with latency 1: a resolve in cycle T drives bp_upd_* in T+1, one pulse per valid resolve.
- Age: age(x) = (x - rob_head_idx_i) mod 2**ROB_IDX_W; a smaller age is older.
- FSM IDLE:
  - A valid resolve with mis → FLUSH.
  - Latch redirect_pc and mispredict_rob_idx.
  - In the same cycle, clear the valid bit of every entry younger than the mispredicting branch.
- FSM FLUSH (one cycle):
  - mispredict_o=1, busy_o=1 → WAIT.
- FSM WAIT:
  - busy_o=1, mispredict_o=0.
  - recover_ack_i → IDLE, with busy_o=0 from the next cycle.
- Resolve during FLUSH or WAIT:
  - The bp update is still emitted.
  - If it mispredicts and is strictly older than the latched branch: re-latch PC and index, invalidate entries younger than it, → FLUSH.
  - If it is younger, or it is a correct prediction, the FSM is unaffected.
- Dispatch and resolve in the same cycle to different indices: both take effect.
- Dispatch and resolve to the same index in the same cycle cannot legally occur; resolve takes priority.
- recover_ack_i in IDLE or FLUSH is ignored.
- rst mid-recovery: abort to IDLE and clear the table.
- redirect_pc_o and mispredict_rob_idx_o hold their values until the next mispredict latch.

Optional Feature:
- Macro BR_RESOLVE_STATS_EN.
- Defined:
  - Adds outputs stat_resolved_o[31:0] and stat_mispred_o[31:0], both 0 on reset.
  - Each counts valid resolves and mispredicts respectively, incrementing in the cycle bp_upd_valid_o is asserted.
  - Both saturate at 0xFFFFFFFF.
- Undefined: no such ports and no counter logic; all other behaviour is identical.

Test Plan:
- Dispatch idx 3 (npc 0x104, pred taken, target 0x200); resolve idx 3 taken with target 0x200 → bp_upd_valid_o=1 one cycle later with pc 0x100, taken 1; mispredict_o stays 0; entry 3 invalid.
- Dispatch idx 4 (npc 0x204, pred not-taken); resolve taken with target 0x300 → next cycle mispredict_o=1 for 1 cycle, redirect_pc_o=0x300, mispredict_rob_idx_o=4; busy_o=1 until one cycle after recover_ack_i.
- Head 0; branches at idx 2 and 6 both valid; resolve 6 mispredicting, then in WAIT resolve 2 mispredicting (not-taken, npc 0x40) → second flush pulse with redirect 0x40 and idx 2; entry 6 already invalidated, so a later br_done_i for 6 produces no output.
- Head 30 (ROB_IDX_W=5); mispredict at idx 1 with a valid entry at idx 31 → entry 31 (older) stays valid, entries 2..29 are cleared.
- br_done_i for never-dispatched idx 9 → no outputs; disp_en_i while busy_o=1 → entry not written; rst asserted in WAIT → busy_o=0 and all outputs 0 next cycle.
- With BR_RESOLVE_STATS_EN: 3 correct resolves plus 1 mispredict → stat_resolved_o=4, stat_mispred_o=1.
